// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - round-robin arbiter sharing one burst read channel
// between icache, dcache and uncached requesters, with a burst-length check.
module mem_read_arbiter #(
  parameter  int N_REQ  = 3,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 4,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    resp_last,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [ADDR_W-1:0]       ar_addr,
  output logic [LEN_W-1:0]        ar_len,
  output logic [ID_W-1:0]         ar_id,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [DATA_W-1:0]       r_data,
  input  logic                    r_last,
  output logic                    proto_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W:0]      cnt_q;
  logic                proto_err_q;
  logic                win_found;
  logic [ID_W-1:0]     win_idx, cand_id;
  logic                r_hs;

  // First pending requester at or after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_id   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_id = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    ar_valid   = 1'b0;
    resp_valid = '0;
    r_ready    = 1'b0;
    resp_data  = '0;
    resp_last  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so the grant cannot leak out while reset is held.
        if (win_found && rst) begin
          req_ready[win_idx] = 1'b1;
          state_d            = ADDR;
        end
      end
      ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_d = DATA;
      end
      DATA: begin
        resp_valid[id_q] = r_valid;
        r_ready          = resp_ready[id_q];
        resp_data        = r_data;
        resp_last        = r_last;
        if (r_valid && resp_ready[id_q] && r_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign r_hs = (state_q == DATA) && r_valid && r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && win_found) begin
        id_q   <= win_idx;
        addr_q <= req_addr[win_idx*ADDR_W +: ADDR_W];
        len_q  <= req_len[win_idx*LEN_W +: LEN_W];
        cnt_q  <= '0;
      end
      if (r_hs) begin
        // Saturate so an overlong malformed burst cannot wrap back to "legal".
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (r_last) begin
          ptr_q <= ID_W'((int'(id_q) + 1) % N_REQ);
          if (cnt_q != {1'b0, len_q}) proto_err_q <= 1'b1;
        end else if (cnt_q >= {1'b0, len_q}) begin
          proto_err_q <= 1'b1;
        end
      end
    end
  end

  assign ar_addr   = addr_q;
  assign ar_len    = len_q;
  assign ar_id     = id_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - randomized self-checking bench for mem_read_arbiter
// against a transaction-level round-robin and burst-length model.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [95:0] req_addr;
  logic [11:0] req_len;
  logic [31:0] resp_data, ar_addr, r_data;
  logic        resp_last, ar_valid, ar_ready, r_valid, r_ready, r_last, proto_err;
  logic [3:0]  ar_len;
  logic [1:0]  ar_id;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] a_addr [3];
  logic [3:0]  a_len [3];

  always #5 clk = ~clk;

  mem_read_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
    .proto_err(proto_err)
  );

  function automatic int onehot_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int model_winner(input logic [2:0] mask, input int p);
    for (int i = 0; i < 3; i++) if (mask[(p + i) % 3]) return (p + i) % 3;
    return -1;
  endfunction

  task automatic reset_dut();
    rst = 1'b0; req_valid = '0; resp_ready = '0; ar_ready = 1'b0;
    r_valid = 1'b0; r_last = 1'b0; r_data = '0; req_addr = '0; req_len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one full transaction and records what the DUT did; callers judge it.
  task automatic run_txn(input logic [2:0] mask, input bit hold, input int nbeats, input int stall,
                         input int rmode, input int pulse_at,
                         output int gid, output int beats, output int route_err, output int addr_err,
                         output logic [31:0] seen_addr, output logic [3:0] seen_len, output int seen_id);
    int sent, it;
    logic [2:0] rr;
    gid = -1; beats = 0; route_err = 0; addr_err = 0; seen_addr = '0; seen_len = '0; seen_id = -1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_addr[i*32 +: 32] = a_addr[i];
      req_len[i*4 +: 4]    = a_len[i];
    end
    req_valid = mask; r_valid = 1'b1; r_data = $urandom; r_last = 1'b0; ar_ready = 1'b0;
    #1;
    gid = onehot_idx(req_ready);
    if (ar_valid !== 1'b0 || r_ready !== 1'b0 || resp_valid !== 3'b000) addr_err++;
    if (gid < 0) begin
      req_valid = '0; r_valid = 1'b0;
      return;
    end
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = hold ? mask : 3'b000;
      ar_ready = (c == stall); r_valid = 1'b1; r_data = $urandom;
      #1;
      if (c == 0) begin seen_addr = ar_addr; seen_len = ar_len; seen_id = int'(ar_id); end
      if (ar_valid !== 1'b1 || ar_addr !== seen_addr || ar_len !== seen_len || int'(ar_id) !== seen_id) addr_err++;
      if (r_ready !== 1'b0 || resp_valid !== 3'b000 || req_ready !== 3'b000) addr_err++;
    end
    sent = 0; it = 0;
    while (sent < nbeats && it < 400) begin
      @(negedge clk);
      ar_ready = 1'b0;
      req_valid = hold ? mask : 3'b000;
      if (it == pulse_at) req_valid[2] = 1'b1;
      r_valid = ($urandom_range(3) != 0); r_data = $urandom; r_last = (sent == nbeats - 1);
      rr = 3'($urandom);
      if (rmode == 0) rr[gid[1:0]] = 1'b1;
      else if (rmode == 1) rr[gid[1:0]] = it[0];
      resp_ready = rr;
      #1;
      if (resp_valid !== (r_valid ? (3'b001 << gid[1:0]) : 3'b000)) route_err++;
      if (r_ready !== rr[gid[1:0]] || resp_data !== r_data || resp_last !== r_last) route_err++;
      if (req_ready !== 3'b000 || ar_valid !== 1'b0) route_err++;
      if (resp_valid[gid[1:0]] && resp_ready[gid[1:0]]) beats++;
      if (r_valid && rr[gid[1:0]]) sent++;
      it++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 3'b111; resp_ready = 3'b111; ar_ready = 1'b1;
    r_valid = 1'b1; r_last = 1'b1; r_data = 32'hdead_beef; req_addr = '1; req_len = '1;
    @(negedge clk); #1;
    total_cnt++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready got %b want 000", req_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 3'b000) $display("FAIL reset_resp_valid got %b want 000", resp_valid); else pass_cnt++;
    total_cnt++; if (ar_valid !== 1'b0) $display("FAIL reset_ar_valid got %b want 0", ar_valid); else pass_cnt++;
    total_cnt++; if (r_ready !== 1'b0) $display("FAIL reset_r_ready got %b want 0", r_ready); else pass_cnt++;
    total_cnt++; if (resp_last !== 1'b0) $display("FAIL reset_resp_last got %b want 0", resp_last); else pass_cnt++;
    total_cnt++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got %h want 0", resp_data); else pass_cnt++;
    total_cnt++; if (ar_addr !== 32'h0) $display("FAIL reset_ar_addr got %h want 0", ar_addr); else pass_cnt++;
    total_cnt++; if (ar_len !== 4'h0) $display("FAIL reset_ar_len got %h want 0", ar_len); else pass_cnt++;
    total_cnt++; if (ar_id !== 2'd0) $display("FAIL reset_ar_id got %0d want 0", ar_id); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got %b want 0", proto_err); else pass_cnt++;
  endtask

  task automatic test_single();
    int gid, beats, re, ae, sid;
    logic [31:0] sa;
    logic [3:0] sl;
    reset_dut();
    for (int i = 0; i < 3; i++) begin a_addr[i] = $urandom; a_len[i] = 4'(i); end
    a_addr[1] = 32'h1fc0_0000; a_len[1] = 4'd3;
    run_txn(3'b010, 1'b0, 4, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
    total_cnt++; if (gid !== 1) $display("FAIL single_grant got %0d want 1", gid); else pass_cnt++;
    total_cnt++; if (sid !== 1) $display("FAIL single_ar_id got %0d want 1", sid); else pass_cnt++;
    total_cnt++; if (sl !== 4'd3) $display("FAIL single_ar_len got %0d want 3", sl); else pass_cnt++;
    total_cnt++; if (sa !== 32'h1fc0_0000) $display("FAIL single_ar_addr got %h want 1fc00000", sa); else pass_cnt++;
    total_cnt++; if (beats !== 4) $display("FAIL single_beats got %0d want 4", beats); else pass_cnt++;
    total_cnt++; if (re !== 0) $display("FAIL single_routing got %0d errors want 0", re); else pass_cnt++;
    total_cnt++; if (ae !== 0) $display("FAIL single_addr_phase got %0d errors want 0", ae); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b0) $display("FAIL single_proto_err got %b want 0", proto_err); else pass_cnt++;
    run_txn(3'b111, 1'b0, 3, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
    total_cnt++; if (gid !== 2) $display("FAIL single_next_ptr got %0d want 2", gid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int gid, beats, re, ae, sid;
    logic [31:0] sa;
    logic [3:0] sl;
    int exp_order [4] = '{0, 1, 2, 0};
    reset_dut();
    for (int i = 0; i < 3; i++) begin a_addr[i] = $urandom; a_len[i] = 4'd0; end
    for (int k = 0; k < 4; k++) begin
      run_txn(3'b111, 1'b1, 1, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
      total_cnt++; if (gid !== exp_order[k]) $display("FAIL rr_grant_%0d got %0d want %0d", k, gid, exp_order[k]); else pass_cnt++;
      total_cnt++; if (beats !== 1) $display("FAIL rr_beats_%0d got %0d want 1", k, beats); else pass_cnt++;
      total_cnt++; if (re + ae !== 0) $display("FAIL rr_protocol_%0d got %0d errors want 0", k, re + ae); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    int gid, beats, re, ae, sid;
    logic [31:0] sa;
    logic [3:0] sl;
    reset_dut();
    for (int i = 0; i < 3; i++) a_addr[i] = $urandom;
    a_len[0] = 4'd7;
    run_txn(3'b001, 1'b0, 8, 5, 1, -1, gid, beats, re, ae, sa, sl, sid);
    total_cnt++; if (ae !== 0) $display("FAIL bp_ar_hold got %0d errors want 0", ae); else pass_cnt++;
    total_cnt++; if (sa !== a_addr[0]) $display("FAIL bp_ar_addr got %h want %h", sa, a_addr[0]); else pass_cnt++;
    total_cnt++; if (beats !== 8) $display("FAIL bp_beats got %0d want 8", beats); else pass_cnt++;
    total_cnt++; if (re !== 0) $display("FAIL bp_r_ready_mirror got %0d errors want 0", re); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b0) $display("FAIL bp_proto_err got %b want 0", proto_err); else pass_cnt++;
  endtask

  task automatic test_mismatch();
    int gid, beats, re, ae, sid;
    logic [31:0] sa;
    logic [3:0] sl;
    reset_dut();
    a_len[0] = 4'd2; a_len[1] = 4'd3;
    run_txn(3'b010, 1'b0, 2, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
    @(posedge clk); #1;
    total_cnt++; if (proto_err !== 1'b1) $display("FAIL mm_proto_err_set got %b want 1", proto_err); else pass_cnt++;
    total_cnt++; if (beats !== 2) $display("FAIL mm_short_beats got %0d want 2", beats); else pass_cnt++;
    run_txn(3'b001, 1'b0, 3, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
    @(posedge clk); #1;
    total_cnt++; if (gid !== 0) $display("FAIL mm_back_to_idle got %0d want 0", gid); else pass_cnt++;
    total_cnt++; if (beats !== 3) $display("FAIL mm_good_beats got %0d want 3", beats); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b1) $display("FAIL mm_proto_err_sticky got %b want 1", proto_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int gid, beats, re, ae, sid;
    logic [31:0] sa;
    logic [3:0] sl;
    reset_dut();
    for (int i = 0; i < 3; i++) begin a_addr[i] = $urandom | 32'h1; a_len[i] = 4'd3; end
    run_txn(3'b001, 1'b0, 4, 0, 0, -1, gid, beats, re, ae, sa, sl, sid);
    @(negedge clk);
    req_valid = 3'b010; ar_ready = 1'b1; r_valid = 1'b0; r_last = 1'b0; resp_ready = 3'b111;
    #1;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL mid_grant got %b want 010", req_ready); else pass_cnt++;
    @(negedge clk); req_valid = 3'b000;
    @(negedge clk); r_valid = 1'b1; r_data = $urandom; ar_ready = 1'b0;
    @(negedge clk); r_data = $urandom;
    #1;
    total_cnt++; if (resp_valid !== 3'b010) $display("FAIL mid_beat2 got %b want 010", resp_valid); else pass_cnt++;
    rst = 1'b0; req_valid = 3'b111;
    #1;
    total_cnt++; if (ar_valid !== 1'b0 || r_ready !== 1'b0) $display("FAIL mid_async_drop got ar_valid=%b r_ready=%b want 0 0", ar_valid, r_ready); else pass_cnt++;
    total_cnt++; if (resp_valid !== 3'b000 || req_ready !== 3'b000) $display("FAIL mid_vectors got resp_valid=%b req_ready=%b want 000 000", resp_valid, req_ready); else pass_cnt++;
    total_cnt++; if (resp_last !== 1'b0 || resp_data !== 32'h0) $display("FAIL mid_resp got last=%b data=%h want 0 0", resp_last, resp_data); else pass_cnt++;
    total_cnt++; if (ar_addr !== 32'h0 || ar_len !== 4'h0 || ar_id !== 2'd0) $display("FAIL mid_ar_fields got %h %h %0d want 0 0 0", ar_addr, ar_len, ar_id); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; r_valid = 1'b0; req_valid = 3'b111;
    #1;
    total_cnt++; if (req_ready !== 3'b001) $display("FAIL mid_ptr_reset got %b want 001", req_ready); else pass_cnt++;
  endtask

  task automatic test_withdrawal();
    int gid, beats, re, ae, sid, bad;
    logic [31:0] sa;
    logic [3:0] sl;
    reset_dut();
    a_len[0] = 4'd5;
    run_txn(3'b001, 1'b0, 6, 0, 2, 1, gid, beats, re, ae, sa, sl, sid);
    total_cnt++; if (gid !== 0) $display("FAIL wd_grant got %0d want 0", gid); else pass_cnt++;
    total_cnt++; if (beats !== 6) $display("FAIL wd_beats got %0d want 6", beats); else pass_cnt++;
    total_cnt++; if (re !== 0) $display("FAIL wd_no_grant_mid_burst got %0d errors want 0", re); else pass_cnt++;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); req_valid = 3'b000; #1;
      if (ar_valid !== 1'b0 || req_ready !== 3'b000) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL wd_no_extra_ar got %0d bad cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b0) $display("FAIL wd_proto_err got %b want 0", proto_err); else pass_cnt++;
  endtask

  task automatic test_random();
    int gid, beats, re, ae, sid, w, nb, mptr;
    logic [31:0] sa;
    logic [3:0] sl;
    logic [2:0] mask;
    logic merr;
    reset_dut();
    mptr = 0; merr = 1'b0;
    for (int k = 0; k < 25; k++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin a_addr[i] = $urandom; a_len[i] = 4'($urandom_range(0, 15)); end
      w = model_winner(mask, mptr);
      nb = ($urandom_range(3) == 0) ? $urandom_range(1, int'(a_len[w]) + 3) : int'(a_len[w]) + 1;
      if (nb != int'(a_len[w]) + 1) merr = 1'b1;
      run_txn(mask, 1'b0, nb, $urandom_range(0, 3), 2, -1, gid, beats, re, ae, sa, sl, sid);
      @(posedge clk); #1;
      total_cnt++; if (gid !== w) $display("FAIL rnd%0d_grant got %0d want %0d", k, gid, w); else pass_cnt++;
      total_cnt++; if (sa !== a_addr[w]) $display("FAIL rnd%0d_ar_addr got %h want %h", k, sa, a_addr[w]); else pass_cnt++;
      total_cnt++; if (sl !== a_len[w]) $display("FAIL rnd%0d_ar_len got %0d want %0d", k, sl, a_len[w]); else pass_cnt++;
      total_cnt++; if (beats !== nb) $display("FAIL rnd%0d_beats got %0d want %0d", k, beats, nb); else pass_cnt++;
      total_cnt++; if (re + ae !== 0) $display("FAIL rnd%0d_protocol got %0d errors want 0", k, re + ae); else pass_cnt++;
      total_cnt++; if (proto_err !== merr) $display("FAIL rnd%0d_proto_err got %b want %b", k, proto_err, merr); else pass_cnt++;
      mptr = (w + 1) % 3;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mismatch();
    test_reset_mid();
    test_withdrawal();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
